// File: rtl/coin_pkg.sv
// Shared definitions for the coin credit register: coin face values,
// default credit ceiling and credit register width.
package coin_pkg;

    localparam int CREDIT_W           = 10;
    localparam int NUM_CHANNELS       = 4;
    localparam int MAX_CHANNELS       = 8;
    localparam int DEFAULT_MAX_CREDIT = 500;

    // Channels 0..3 are the standard coins; 4..7 only matter for wider builds.
    localparam int unsigned COIN_VAL [0:MAX_CHANNELS-1] = '{5, 10, 25, 100, 1, 2, 50, 200};

    typedef logic [CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/coin_prio_sel.sv
// Lowest-index coin channel selector: reports the winning index, whether any
// channel was asserted, and whether more than one was asserted.
module coin_prio_sel #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    output logic [IDX_W-1:0]    idx,
    output logic                vld,
    output logic                multi
);

    always_comb begin
        idx = '0;
        vld = |req;
        // Any bit left after clearing the lowest set bit means a second coin.
        multi = |(req & (req - CHANNELS'(1)));
        // Scan downward so the lowest asserted index is written last.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/coin_credit_reg.sv
// Coin credit register: accumulates accepted coins, deducts spends, saturates
// at MAX_CREDIT and emits registered one-cycle acknowledge/refuse pulses.
module coin_credit_reg
    import coin_pkg::*;
#(
    parameter int WIDTH      = CREDIT_W,
    parameter int CHANNELS   = NUM_CHANNELS,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] coin_valid,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic                spend_valid,
    input  logic [WIDTH-1:0]    spend_amt,
    input  logic                clear,
    output logic [WIDTH-1:0]    credit,
    output logic                coin_ack,
    output logic                coin_rej,
    output logic                spend_ack,
    output logic                spend_nak,
    output logic                sat
);

    localparam int             IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_CREDIT);

    function automatic logic [WIDTH:0] coin_value(input logic [IDX_W-1:0] i);
        return (WIDTH+1)'(COIN_VAL[int'(i)]);
    endfunction

    function automatic logic within_ceiling(input logic [WIDTH:0] v);
        return v <= MAX_EXT;
    endfunction

    logic [IDX_W-1:0] sel_idx_p0;
    logic             sel_vld_p0;
    logic             sel_multi_p0;
    logic [WIDTH:0]   credit_ext_p0;
    logic [WIDTH:0]   coin_add_p0;
    logic [WIDTH:0]   spend_sub_p0;
    logic [WIDTH:0]   next_credit_p0;
    logic             coin_ok_p0;
    logic             spend_ok_p0;

    coin_prio_sel #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_sel (
        .req   (coin_valid),
        .idx   (sel_idx_p0),
        .vld   (sel_vld_p0),
        .multi (sel_multi_p0)
    );

    // ---- p0: request evaluation (combinational) ----
    always_comb begin
        credit_ext_p0  = {1'b0, credit};
        coin_ok_p0     = 1'b0;
        coin_add_p0    = '0;
        spend_ok_p0    = 1'b0;
        spend_sub_p0   = '0;
        next_credit_p0 = credit_ext_p0;

        if (sel_vld_p0 && en && !clear && chan_mask[sel_idx_p0] &&
            within_ceiling(credit_ext_p0 + coin_value(sel_idx_p0))) begin
            coin_ok_p0  = 1'b1;
            coin_add_p0 = coin_value(sel_idx_p0);
        end

        // A coin landing in the same cycle may fund the spend.
        if (spend_valid && en && !clear &&
            ({1'b0, spend_amt} <= credit_ext_p0 + coin_add_p0)) begin
            spend_ok_p0  = 1'b1;
            spend_sub_p0 = {1'b0, spend_amt};
        end

        if (clear) begin
            next_credit_p0 = '0;
        end else begin
            next_credit_p0 = credit_ext_p0 + coin_add_p0 - spend_sub_p0;
        end
    end

    // ---- p1: registered credit and status pulses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit    <= '0;
            coin_ack  <= 1'b0;
            coin_rej  <= 1'b0;
            spend_ack <= 1'b0;
            spend_nak <= 1'b0;
            sat       <= 1'b0;
        end else begin
            credit    <= next_credit_p0[WIDTH-1:0];
            coin_ack  <= coin_ok_p0;
            coin_rej  <= (sel_vld_p0 && !coin_ok_p0) || sel_multi_p0;
            spend_ack <= spend_ok_p0;
            spend_nak <= spend_valid && !spend_ok_p0;
            sat       <= (next_credit_p0 == MAX_EXT);
        end
    end

endmodule

// File: tb/tb_coin_credit_reg.sv
// Directed bench for coin_credit_reg with a behavioural model feeding an
// expected-result queue that is drained one cycle after each request.
module tb_coin_credit_reg;

    typedef struct packed {
        logic [9:0] credit;
        logic       coin_ack;
        logic       coin_rej;
        logic       spend_ack;
        logic       spend_nak;
        logic       sat;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] coin_valid;
    logic [3:0] chan_mask;
    logic       spend_valid;
    logic [9:0] spend_amt;
    logic       clear;
    logic [9:0] credit;
    logic       coin_ack, coin_rej, spend_ack, spend_nak, sat;

    int    checks   = 0;
    int    failures = 0;
    int    m_credit = 0;
    int    coin_tab [4] = '{5, 10, 25, 100};
    obs_t  exp_q [$];
    string tag_q [$];

    coin_credit_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .coin_valid  (coin_valid),
        .chan_mask   (chan_mask),
        .spend_valid (spend_valid),
        .spend_amt   (spend_amt),
        .clear       (clear),
        .credit      (credit),
        .coin_ack    (coin_ack),
        .coin_rej    (coin_rej),
        .spend_ack   (spend_ack),
        .spend_nak   (spend_nak),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        obs_t o;
        o.credit    = credit;
        o.coin_ack  = coin_ack;
        o.coin_rej  = coin_rej;
        o.spend_ack = spend_ack;
        o.spend_nak = spend_nak;
        o.sat       = sat;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (credit %0d vs %0d)",
                   tag, got, want, got.credit, want.credit);
        end
    endtask

    // Reference behaviour for one request cycle; updates the model credit.
    task automatic model_push(input string tag);
        obs_t e;
        int   first = -1;
        int   count = 0;
        int   add   = 0;
        bit   c_ok  = 0;
        bit   s_ok  = 0;
        for (int i = 0; i < 4; i++) begin
            if (coin_valid[i]) begin
                if (first < 0) first = i;
                count++;
            end
        end
        if (first >= 0 && en && !clear && chan_mask[first] &&
            m_credit + coin_tab[first] <= 500) begin
            c_ok = 1;
            add  = coin_tab[first];
        end
        if (spend_valid && en && !clear && int'(spend_amt) <= m_credit + add)
            s_ok = 1;
        if (clear) m_credit = 0;
        else       m_credit = m_credit + add - (s_ok ? int'(spend_amt) : 0);
        e.credit    = 10'(m_credit);
        e.coin_ack  = c_ok;
        e.coin_rej  = (first >= 0 && !c_ok) || (count > 1);
        e.spend_ack = s_ok;
        e.spend_nak = spend_valid && !s_ok;
        e.sat       = (m_credit == 500);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            check(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    endtask

    task automatic step(input string tag, input logic [3:0] cv, input logic [3:0] mk,
                        input logic sv, input logic [9:0] amt, input logic clr,
                        input logic e);
        @(negedge clk);
        coin_valid  = cv;
        chan_mask   = mk;
        spend_valid = sv;
        spend_amt   = amt;
        clear       = clr;
        en          = e;
        model_push(tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        obs_t zero_obs;
        zero_obs    = '0;
        rst_n       = 1'b0;
        en          = 1'b1;
        coin_valid  = '0;
        chan_mask   = 4'b1111;
        spend_valid = 1'b0;
        spend_amt   = '0;
        clear       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), zero_obs);
        @(negedge clk);
        rst_n = 1'b1;

        // Four 5-unit coins on channel 0
        for (int i = 0; i < 4; i++) step("coin_ch0_accum", 4'b0001, 4'b1111, 0, 0, 0, 1);

        // Climb to 495, then ceiling behaviour
        for (int i = 0; i < 4; i++) step("coin_ch3_climb", 4'b1000, 4'b1111, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("coin_ch2_climb", 4'b0100, 4'b1111, 0, 0, 0, 1);
        step("ceiling_reject", 4'b0010, 4'b1111, 0, 0, 0, 1);
        step("ceiling_exact",  4'b0001, 4'b1111, 0, 0, 0, 1);
        step("sat_hold",       4'b0000, 4'b1111, 0, 0, 0, 1);
        step("sat_reject",     4'b0001, 4'b1111, 0, 0, 0, 1);

        // Spend with same-cycle coin, refusal, exact spend
        step("clear_from_sat", 4'b0000, 4'b1111, 0, 0, 1, 1);
        step("coin_25",        4'b0100, 4'b1111, 0, 0, 0, 1);
        step("coin_5",         4'b0001, 4'b1111, 0, 0, 0, 1);
        step("spend25_coin5",  4'b0001, 4'b1111, 1, 25, 0, 1);
        step("spend40_nak",    4'b0000, 4'b1111, 1, 40, 0, 1);
        step("spend_exact",    4'b0000, 4'b1111, 1, 10, 0, 1);
        step("spend_coin_funded", 4'b0001, 4'b1111, 1, 5, 0, 1);

        // Multi-coin priority and channel mask
        step("multi_0110",     4'b0110, 4'b1111, 0, 0, 0, 1);
        step("masked_ch1",     4'b0010, 4'b1101, 0, 0, 0, 1);

        // Global enable low
        step("clear_again",    4'b0000, 4'b1111, 0, 0, 1, 1);
        step("coin_25_a",      4'b0100, 4'b1111, 0, 0, 0, 1);
        step("coin_25_b",      4'b0100, 4'b1111, 0, 0, 0, 1);
        step("en_low_hold",    4'b0001, 4'b1111, 1, 10, 0, 0);
        step("clear_en_low",   4'b0000, 4'b1111, 0, 0, 1, 0);

        // Asynchronous reset in mid-cycle with a request in flight
        step("coin_100",       4'b1000, 4'b1111, 0, 0, 0, 1);
        @(negedge clk);
        coin_valid  = 4'b0001;
        spend_valid = 1'b1;
        spend_amt   = 10'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", observed(), zero_obs);
        @(posedge clk);
        #1;
        check("reset_held_edge", observed(), zero_obs);
        @(negedge clk);
        coin_valid  = '0;
        spend_valid = 1'b0;
        spend_amt   = '0;
        rst_n       = 1'b1;
        m_credit    = 0;
        step("post_reset_idle1", 4'b0000, 4'b1111, 0, 0, 0, 1);
        step("post_reset_idle2", 4'b0000, 4'b1111, 0, 0, 0, 1);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_credit_reg.md
COIN_CREDIT_REG -- requirements
Module: coin_credit_reg

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the credit register width in bits.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of coin input channels (1..8).
REQ-003 Parameter MAX_CREDIT, default 500, SHALL set the saturation ceiling, which must be less than 2**WIDTH.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 en  input  1  SHALL be the global update enable; when low, credit holds.
REQ-007 coin_valid  input  CHANNELS  SHALL be a one-cycle pulse per channel signalling that a coin was inserted.
REQ-008 chan_mask  input  CHANNELS  SHALL be the per-channel accept mask; 1 means the channel is accepted.
REQ-009 spend_valid  input  1  SHALL be a one-cycle request to deduct spend_amt.
REQ-010 spend_amt  input  WIDTH  SHALL be the amount to deduct.
REQ-011 clear  input  1  SHALL be a synchronous credit clear, used for refund or cancel.
REQ-012 credit  output  WIDTH  SHALL be the registered current credit.
REQ-013 coin_ack  output  1  SHALL be a registered one-cycle pulse indicating that a coin was accepted.
REQ-014 coin_rej  output  1  SHALL be a registered one-cycle pulse indicating that a coin was returned.
REQ-015 spend_ack  output  1  SHALL be a registered one-cycle pulse indicating that a spend was applied.
REQ-016 spend_nak  output  1  SHALL be a registered one-cycle pulse indicating that a spend was refused for insufficient credit.
REQ-017 sat  output  1  SHALL be a registered level that is high while credit equals MAX_CREDIT.

Function
REQ-018 Each channel i SHALL carry the value COIN_VAL[i] taken from the shared package.
REQ-019 Coin selection SHALL pick the lowest-index i with coin_valid[i]=1; any other asserted channels in the same cycle SHALL be rejected.
REQ-020 The selected coin SHALL be accepted only if en=1, chan_mask[i]=1, clear=0, and credit + COIN_VAL[i] <= MAX_CREDIT.
REQ-021 A coin that fails REQ-020, or that loses selection under REQ-019, SHALL produce coin_rej=1 in the next cycle; credit is unchanged by that coin.
REQ-022 A spend SHALL be applied only if en=1, clear=0, and spend_amt <= credit plus the value of any coin accepted in the same cycle.
REQ-023 A refused spend SHALL produce spend_nak, and credit SHALL NOT change because of it.
REQ-024 When a coin and a spend both qualify in the same cycle, next credit SHALL be credit + coin - spend, evaluated in WIDTH+1 bits with no wrap.
REQ-025 clear=1 SHALL set credit to 0 on the next edge regardless of en; it SHALL reject any coin and refuse any spend in that cycle.
REQ-026 When en=0, credit SHALL hold, any coin SHALL be rejected, and any spend SHALL be refused; clear still acts as in REQ-025.
REQ-027 All acknowledge and refuse pulses SHALL be asserted for exactly one cycle, one cycle after the request.
REQ-028 sat SHALL be derived from the next-credit value so that it is valid in the same cycle as credit.
REQ-029 Latency from a request edge to the credit update SHALL be 1 clock.

Reset
REQ-030 rst_n=0 SHALL immediately force credit=0 and all pulse outputs and sat to 0, asynchronously.
REQ-031 Reset deassertion SHALL take effect on the next rising clk edge.
REQ-032 An in-flight request coinciding with reset SHALL be dropped, with no acknowledge pulse issued afterwards.

Structure
REQ-033 The package coin_pkg SHALL hold the COIN_VAL array (defaults 5, 10, 25, 100), the default MAX_CREDIT, and the credit type width.
REQ-034 A sub-module coin_prio_sel SHALL implement lowest-index selection, producing an index, a valid flag and a multi-coin flag.
REQ-035 There SHALL be no other state beyond the credit register and the output flops.

Verification
REQ-036 Reset, en=1, mask=1111: pulse coin_valid=0001 four times -> credit reads 5, 10, 15, 20, with coin_ack each time.
REQ-037 At credit=495, insert channel 1 (10) -> coin_rej=1 and credit stays 495; then insert channel 0 (5) -> credit=500 and sat=1.
REQ-038 At credit=30, spend 25 together with a coin on channel 0 -> credit=10 and both coin_ack and spend_ack fire; then spend 40 -> spend_nak and credit stays 10.
REQ-039 Set coin_valid=0110 in one cycle -> channel 1 accepted (+10) and coin_rej=1 for channel 2; set mask=1101 and insert channel 1 -> coin_rej.
REQ-040 With en=0 and credit=50, insert a coin and request a spend -> credit stays 50, with coin_rej and spend_nak; then clear with en=0 -> credit=0.
REQ-041 Assert rst_n=0 mid-cycle at credit=100 -> credit=0 before the next edge, with no pulses after release.
